// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked execute-stage ALU with iterative shifter
// Optional word ops (codes 10..14) enabled by POLARIS_ALU_WORD_OPS_EN.
module alu_seq #(
  parameter int WIDTH      = 64,
  parameter int SHIFT_STEP = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       fn_i,
  input  logic [WIDTH-1:0] inA_i,
  input  logic [WIDTH-1:0] inB_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] out_o,
  output logic             carry_o,
  output logic             zero_o
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;
  typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_t;

  state_t r_state, w_state_nxt;
  logic   w_accept;

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic [SW-1:0]    r_rem;
  kind_t            r_kind;

  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_is_shift;
  kind_t            w_kind;
  logic [SW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_load;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_add;
  logic [WIDTH:0]   w_sum;

  logic [SW:0]      w_step;
  logic             w_shift_done;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shift_fin;

`ifdef POLARIS_ALU_WORD_OPS_EN
  logic             r_word;
  logic             w_word;
  logic [31:0]      w_sum32;

  function automatic logic [WIDTH-1:0] f_sext32(input logic [31:0] x);
    return {{(WIDTH-32){x[31]}}, x};
  endfunction

  assign w_sum32 = (fn_i == 4'd11) ? inA_i[31:0] - inB_i[31:0] : inA_i[31:0] + inB_i[31:0];
`endif

  // SUB is A + ~B + 1 so carry_o reads as NOT borrow.
  assign w_is_sub = (fn_i == 4'd1);
  assign w_b_add  = w_is_sub ? ~inB_i : inB_i;
  assign w_sum    = {1'b0, inA_i} + {1'b0, w_b_add} + {{WIDTH{1'b0}}, w_is_sub};

  always_comb begin
    w_res      = '0;
    w_carry    = 1'b0;
    w_is_shift = 1'b0;
    w_kind     = K_SLL;
    w_shamt    = inB_i[SW-1:0];
    w_load     = inA_i;
`ifdef POLARIS_ALU_WORD_OPS_EN
    w_word     = 1'b0;
`endif
    case (fn_i)
      4'd0, 4'd1: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      4'd2: w_res = inA_i & inB_i;
      4'd3: w_res = inA_i | inB_i;
      4'd4: w_res = inA_i ^ inB_i;
      4'd5: w_res = {{(WIDTH-1){1'b0}}, ($signed(inA_i) < $signed(inB_i))};
      4'd6: w_res = {{(WIDTH-1){1'b0}}, (inA_i < inB_i)};
      4'd7: begin w_is_shift = 1'b1; w_kind = K_SLL; end
      4'd8: begin w_is_shift = 1'b1; w_kind = K_SRL; end
      4'd9: begin w_is_shift = 1'b1; w_kind = K_SRA; end
`ifdef POLARIS_ALU_WORD_OPS_EN
      4'd10, 4'd11: w_res = f_sext32(w_sum32);
      4'd12, 4'd13, 4'd14: begin
        w_is_shift = 1'b1;
        w_word     = 1'b1;
        w_shamt    = SW'(inB_i[4:0]);
        w_kind     = (fn_i == 4'd12) ? K_SLL : (fn_i == 4'd13) ? K_SRL : K_SRA;
        w_load     = (fn_i == 4'd14) ? f_sext32(inA_i[31:0])
                                     : {{(WIDTH-32){1'b0}}, inA_i[31:0]};
      end
`endif
      default: ;
    endcase
    // Zero-amount shifts complete immediately with the (finalised) operand.
    if (w_is_shift) begin
`ifdef POLARIS_ALU_WORD_OPS_EN
      w_res = w_word ? f_sext32(w_load[31:0]) : w_load;
`else
      w_res = w_load;
`endif
    end
  end

  assign w_step       = ({1'b0, r_rem} > STEP) ? STEP : {1'b0, r_rem};
  assign w_shift_done = ({1'b0, r_rem} <= STEP);

  always_comb begin
    w_shift_nxt = r_out;
    case (r_kind)
      K_SLL:   w_shift_nxt = r_out << w_step;
      K_SRL:   w_shift_nxt = r_out >> w_step;
      K_SRA:   w_shift_nxt = WIDTH'($signed(r_out) >>> w_step);
      default: w_shift_nxt = r_out;
    endcase
  end

`ifdef POLARIS_ALU_WORD_OPS_EN
  assign w_shift_fin = r_word ? f_sext32(w_shift_nxt[31:0]) : w_shift_nxt;
`else
  assign w_shift_fin = w_shift_nxt;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_is_shift && (w_shamt != '0)) ? S_SHIFT : S_HOLD;
        end
      end
      S_SHIFT: if (w_shift_done) w_state_nxt = S_HOLD;
      S_HOLD: begin
        valid_o = 1'b1;
        if (ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_out   <= '0;
      r_carry <= 1'b0;
      r_rem   <= '0;
      r_kind  <= K_SLL;
`ifdef POLARIS_ALU_WORD_OPS_EN
      r_word  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_out   <= (w_state_nxt == S_SHIFT) ? w_load : w_res;
      r_carry <= w_carry;
      r_rem   <= w_shamt;
      r_kind  <= w_kind;
`ifdef POLARIS_ALU_WORD_OPS_EN
      r_word  <= w_word;
`endif
    end else if (r_state == S_SHIFT) begin
      r_out <= w_shift_done ? w_shift_fin : w_shift_nxt;
      r_rem <= r_rem - w_step[SW-1:0];
    end
  end

  assign out_o   = r_out;
  assign carry_o = r_carry;
  assign zero_o  = (r_out == '0);

endmodule
